// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Loads a program image into the core's instruction memory.
//
//   A byte stream arrives over a valid/ready handshake:
//     byte 0..1 : LEN, the word count, little-endian
//     then      : LEN*4 data bytes, least-significant byte of each word first
//   Each assembled 32-bit word is written to consecutive word addresses with
//   a one-cycle write strobe. The core is held in reset until the final
//   write has completed.
//
// Ports:
//   clk         system clock, rising-edge
//   rst         asynchronous active-low reset
//   s_valid     input byte valid
//   s_data      input byte
//   s_ready     loader can accept a byte this cycle
//   we          instruction-memory write strobe, one cycle per word
//   waddr       word address of the write (byte address = waddr*4)
//   wdata       word to write
//   done        image fully written, sticky until reset
//   err         declared length exceeds DEPTH, sticky until reset
//   core_rst_n  active-low reset to the core, released together with done
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              done,
  output logic              err,
  output logic              core_rst_n
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;        // lanes 0..2; lane 3 comes straight from s_data
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic              r_core_rst_n;

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_len_full;

  // Readiness is a function of state only; FLUSH is only ready while words
  // remain, which never holds once the last word has been issued.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN_LO,
      S_LEN_HI,
      S_DATA:   w_ready = 1'b1;
      S_FLUSH:  w_ready = (r_word_cnt < r_len);
      default:  w_ready = 1'b0;
    endcase
  end

  // Gating with rst keeps s_ready low for the whole time reset is held.
  assign s_ready    = rst & w_ready;
  assign w_accept   = s_valid & s_ready;
  assign w_len_full = {s_data, r_len[7:0]};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers; blocking here would create
  // order-dependent simulation and a mismatch with the synthesized netlist.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers (r_asm, r_waddr, r_wdata) are reset too,
      // because the reset values of waddr/wdata are externally visible.
      r_state      <= S_LEN_LO;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      // NOTE: default-low each cycle makes the strobe a single-cycle pulse
      // without needing a separate clear path in every state.
      r_we <= 1'b0;

      case (r_state)
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= s_data;
            r_state    <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= s_data;
            if (w_len_full == 16'd0) begin
              r_state <= S_DONE;
            end else if (w_len_full > 16'(DEPTH)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps 3 -> 0
            case (r_byte_cnt)
              2'd0: r_asm[7:0]   <= s_data;
              2'd1: r_asm[15:8]  <= s_data;
              2'd2: r_asm[23:16] <= s_data;
              default: begin
                r_wdata    <= {s_data, r_asm};
                r_waddr    <= r_word_cnt[ADDR_W-1:0];
                r_we       <= 1'b1;
                r_word_cnt <= r_word_cnt + 16'd1;
                if (r_word_cnt == r_len - 16'd1) begin
                  r_state <= S_FLUSH;
                end
              end
            endcase
          end
        end

        // The last strobe is on the bus this cycle; leave one edge for the
        // memory to complete the write before declaring done.
        S_FLUSH: begin
          r_state <= S_DONE;
        end

        // done/core_rst_n are registered from the state so the core leaves
        // reset strictly after the final write cycle.
        S_DONE: begin
          r_done       <= 1'b1;
          r_core_rst_n <= 1'b1;
        end

        S_ERR: begin
          r_err <= 1'b1;
        end

        default: begin
          r_state <= S_LEN_LO;
        end
      endcase
    end
  end

  assign we         = r_we;
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign done       = r_done;
  assign err        = r_err;
  assign core_rst_n = r_core_rst_n;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader. Stimulus pushes the expected
//   {waddr, wdata} of each write into a scoreboard queue; an independent
//   monitor pops and compares on every cycle where we=1.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              done;
  logic              err;
  logic              core_rst_n;

  wr_t exp_q[$];
  int  n_checks;
  int  n_pass;
  int  n_we;

  logic [7:0] img1 [10] = '{8'h02, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF,
                            8'h23, 8'hA4, 8'h64, 8'h00};
  logic [7:0] img5 [6]  = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && we === 1'b1) begin
      n_we++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 32'(waddr), 32'(e.addr));
        check("wdata", wdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Present one byte and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   n;
    s_valid = 1'b1;
    s_data  = b;
    n       = 0;
    do begin
      acc = s_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    tick();
    n_we = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_we     = 0;
    rst      = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;

    // Reset state
    #3;
    check("rst_s_ready",    32'(s_ready),    32'd0);
    check("rst_we",         32'(we),         32'd0);
    check("rst_waddr",      32'(waddr),      32'd0);
    check("rst_wdata",      wdata,           32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    #10;
    rst = 1'b1;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd1);

    // Test 1: two-word image, back-to-back
    push(10'd0, 32'hFFC4A303);
    push(10'd1, 32'h0064A423);
    for (int i = 0; i < 10; i++) send_byte(img1[i]);
    check("t1_we_last",     32'(we),   32'd1);
    check("t1_done_at_e",   32'(done), 32'd0);
    tick();
    check("t1_done_at_e1",  32'(done), 32'd0);
    check("t1_we_single",   32'(we),   32'd0);
    tick();
    check("t1_done",        32'(done),       32'd1);
    check("t1_core_rst_n",  32'(core_rst_n), 32'd1);
    check("t1_we_count",    32'(n_we),       32'd2);

    // Test 6: post-done traffic is refused and outputs hold
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      check("t6_s_ready", 32'(s_ready), 32'd0);
      tick();
      check("t6_we",     32'(we),         32'd0);
      check("t6_waddr",  32'(waddr),      32'd1);
      check("t6_wdata",  wdata,           32'h0064A423);
      check("t6_done",   32'(done),       32'd1);
      check("t6_core",   32'(core_rst_n), 32'd1);
    end
    s_valid = 1'b0;
    check("t6_we_count", 32'(n_we), 32'd2);

    // Test 2: empty image
    pulse_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    check("t2_done",       32'(done),       32'd1);
    check("t2_core_rst_n", 32'(core_rst_n), 32'd1);
    check("t2_s_ready",    32'(s_ready),    32'd0);
    check("t2_we_count",   32'(n_we),       32'd0);

    // Test 3: oversize image (LEN = 0x0401 > 1024)
    pulse_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    tick();
    check("t3_err",        32'(err),        32'd1);
    check("t3_s_ready",    32'(s_ready),    32'd0);
    check("t3_done",       32'(done),       32'd0);
    check("t3_core_rst_n", 32'(core_rst_n), 32'd0);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      check("t3_refuse", 32'(s_ready), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    check("t3_err_held",  32'(err),  32'd1);
    check("t3_we_count",  32'(n_we), 32'd0);

    // Test 4: same image with 1..3 idle cycles between bytes
    pulse_reset();
    push(10'd0, 32'hFFC4A303);
    push(10'd1, 32'h0064A423);
    for (int i = 0; i < 10; i++) begin
      int gap;
      send_byte(img1[i]);
      if (i == 5) check("t4_no_done_after_w0", 32'(done), 32'd0);
      if (i < 9) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) tick();
      end
    end
    check("t4_done_at_e", 32'(done), 32'd0);
    tick();
    tick();
    check("t4_done",       32'(done),       32'd1);
    check("t4_core_rst_n", 32'(core_rst_n), 32'd1);
    check("t4_we_count",   32'(n_we),       32'd2);

    // Test 5: asynchronous reset mid-load, then a one-word image
    pulse_reset();
    push(10'd0, 32'hFFC4A303);
    for (int i = 0; i < 6; i++) send_byte(img1[i]);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_we",         32'(we),         32'd0);
    check("t5_waddr",      32'(waddr),      32'd0);
    check("t5_wdata",      wdata,           32'd0);
    check("t5_done",       32'(done),       32'd0);
    check("t5_err",        32'(err),        32'd0);
    check("t5_core_rst_n", 32'(core_rst_n), 32'd0);
    check("t5_s_ready",    32'(s_ready),    32'd0);
    #8;
    rst = 1'b1;
    tick();
    n_we = 0;
    push(10'd0, 32'h00000013);
    for (int i = 0; i < 6; i++) send_byte(img5[i]);
    tick();
    tick();
    check("t5_reload_done", 32'(done), 32'd1);
    check("t5_we_count",    32'(n_we), 32'd1);

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
